systolic_result_collector: RTL and testbench

Sits at the bottom edge of the monodirectional systolic array and consumes its column results. Column c's result for a given input vector appears c cycles after column 0's result. The collector de-skews the columns into one aligned result vector and buffers it in a small FIFO. It presents the vector downstream with a valid/ready handshake and gives the upstream feeder a credit signal, so it never issues more vectors than can be stored.

---
 rtl/systolic_result_collector.sv | 159 +++++++++++++++
 tb/tb_systolic_result_collector.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_collector.sv
// rtl/systolic_result_collector.sv - de-skews systolic column results into a FWFT FIFO with credit output
// Optional tiled accumulation is enabled by defining COLLECTOR_ACCUM_EN.
module systolic_result_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int COLUMNS    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic                             in_last,
    input  logic [DATA_WIDTH*COLUMNS-1:0]    array_result,
    output logic                             can_accept,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*COLUMNS-1:0]    out_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  occupancy,
    output logic                             overflow
);

    localparam int VW = DATA_WIDTH * COLUMNS;
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(FIFO_DEPTH + COLUMNS + 1);

    logic [COLUMNS-2:0] valid_pipe;
    logic               aligned_valid;
    logic [VW-1:0]      aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= in_valid;
            for (int i = 1; i < COLUMNS - 1; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign aligned_valid = valid_pipe[COLUMNS-2];

    // Column c arrives c cycles late, so it waits COLUMNS-1-c cycles to line up with the last column.
    genvar c;
    for (c = 0; c < COLUMNS - 1; c++) begin : g_skew
        localparam int DEPTH = COLUMNS - 1 - c;
        logic [DATA_WIDTH-1:0] sr [DEPTH];

        always_ff @(posedge clk) begin
            sr[0] <= array_result[c*DATA_WIDTH +: DATA_WIDTH];
            for (int k = 1; k < DEPTH; k++) begin
                sr[k] <= sr[k-1];
            end
        end

        assign aligned[c*DATA_WIDTH +: DATA_WIDTH] = sr[DEPTH-1];
    end

    assign aligned[(COLUMNS-1)*DATA_WIDTH +: DATA_WIDTH] =
        array_result[(COLUMNS-1)*DATA_WIDTH +: DATA_WIDTH];

    logic          push;
    logic [VW-1:0] push_data;

`ifdef COLLECTOR_ACCUM_EN
    logic [COLUMNS-2:0] last_pipe;
    logic [VW-1:0]      acc;
    logic [VW-1:0]      acc_sum;

    always_ff @(posedge clk) begin
        last_pipe[0] <= in_last;
        for (int i = 1; i < COLUMNS - 1; i++) begin
            last_pipe[i] <= last_pipe[i-1];
        end
    end

    always_comb begin
        acc_sum = '0;
        for (int e = 0; e < COLUMNS; e++) begin
            acc_sum[e*DATA_WIDTH +: DATA_WIDTH] = acc[e*DATA_WIDTH +: DATA_WIDTH]
                                                + aligned[e*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (aligned_valid) begin
            acc <= last_pipe[COLUMNS-2] ? '0 : acc_sum;
        end
    end

    assign push      = aligned_valid && last_pipe[COLUMNS-2];
    assign push_data = acc_sum;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign push           = aligned_valid;
    assign push_data      = aligned;
`endif

    logic [VW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          full;
    logic          wr_en;

    assign pop   = out_valid && out_ready;
    assign full  = (occupancy == OW'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !wr_en) begin
                occupancy <= occupancy - 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (occupancy != '0);
    assign out_data  = mem[rd_ptr];

    // Every vector still in the skew pipeline may need a slot, so reserve one per valid bit.
    logic [SW-1:0] inflight;
    logic [SW-1:0] committed;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < COLUMNS - 1; i++) begin
            inflight = inflight + SW'(valid_pipe[i]);
        end
        committed  = SW'(occupancy) + inflight;
        can_accept = (committed < SW'(FIFO_DEPTH));
    end

endmodule

// File: tb/tb_systolic_result_collector.sv
// tb/tb_systolic_result_collector.sv - directed bench with queue-based reference model for systolic_result_collector
module tb_systolic_result_collector;

    localparam int DW = 8;
    localparam int C  = 4;
    localparam int D  = 2;
    localparam int VW = DW * C;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_last;
    logic [VW-1:0] array_result;
    logic          can_accept;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic [1:0]    occupancy;
    logic          overflow;

    always #5 clk = ~clk;

    systolic_result_collector #(
        .DATA_WIDTH(DW),
        .COLUMNS   (C),
        .FIFO_DEPTH(D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .array_result(array_result),
        .can_accept  (can_accept),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .occupancy   (occupancy),
        .overflow    (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic          iv   [N];
    logic          il   [N];
    logic          rdy  [N];
    logic          rs   [N];
    logic [VW-1:0] vec  [N];

    logic          ov   [N];
    logic [VW-1:0] od   [N];
    logic [1:0]    oocc [N];
    logic          oovf [N];
    logic          oca  [N];

    typedef struct {
        int            wr;
        logic [VW-1:0] v;
        logic          last;
    } pend_t;

    pend_t         pq [$];
    logic [VW-1:0] fq [$];
    logic          m_ovf;
    logic [VW-1:0] m_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] add_vec(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        for (int e = 0; e < C; e++) r[e*DW +: DW] = a[e*DW +: DW] + b[e*DW +: DW];
        return r;
    endfunction

    task automatic model_clear();
        pq.delete();
        fq.delete();
        m_ovf = 1'b0;
        m_acc = '0;
    endtask

    // Advance the reference across the clock edge that ends scenario cycle t.
    task automatic model_step(input int t);
        logic          pop;
        logic          full;
        logic          push;
        logic [VW-1:0] pdata;
        pend_t         p;
        if (rs[t]) begin
            model_clear();
            return;
        end
        full  = (fq.size() == D);
        pop   = (fq.size() != 0) && rdy[t];
        push  = 1'b0;
        pdata = '0;
        if (pq.size() != 0 && pq[0].wr == cyc) begin
            p = pq.pop_front();
`ifdef COLLECTOR_ACCUM_EN
            pdata = add_vec(m_acc, p.v);
            if (p.last) begin
                push  = 1'b1;
                m_acc = '0;
            end else begin
                m_acc = pdata;
            end
`else
            push  = 1'b1;
            pdata = p.v;
`endif
        end
        if (pop) void'(fq.pop_front());
        if (push) begin
            if (full && !pop) m_ovf = 1'b1;
            else fq.push_back(pdata);
        end
        if (iv[t]) begin
            p.wr   = cyc + C - 1;
            p.v    = vec[t];
            p.last = il[t];
            pq.push_back(p);
        end
    endtask

    task automatic compare_cycle(input int t);
        ov[t]   = out_valid;
        od[t]   = out_data;
        oocc[t] = occupancy;
        oovf[t] = overflow;
        oca[t]  = can_accept;
        check("out_valid", 32'(out_valid), 32'(fq.size() != 0));
        check("occupancy", 32'(occupancy), 32'(fq.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("can_accept", 32'(can_accept), 32'((fq.size() + pq.size()) < D));
        if (fq.size() != 0) check("out_data", out_data, fq[0]);
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            iv[i]  = 1'b0;
            il[i]  = 1'b1;
            rdy[i] = 1'b0;
            rs[i]  = 1'b0;
            vec[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        cyc++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_can_accept", 32'(can_accept), 32'd1);
        model_clear();
    endtask

    task automatic run(input int n);
        logic [VW-1:0] ar;
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int c = 0; c < C; c++) begin
                ar[c*DW +: DW] = 8'($urandom);
                if (t - c >= 0) begin
                    if (iv[t-c]) ar[c*DW +: DW] = vec[t-c][c*DW +: DW];
                end
            end
            rst          = rs[t];
            in_valid     = iv[t];
            in_last      = il[t];
            out_ready    = rdy[t];
            array_result = ar;
            @(negedge clk);
            compare_cycle(t);
            model_step(t);
        end
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
    endtask

    logic [VW-1:0] v2 [4];

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        out_ready    = 1'b0;
        array_result = '0;
        v2[0] = 32'hA1B2C3D4;
        v2[1] = 32'h01020304;
        v2[2] = 32'hFFEE0011;
        v2[3] = 32'h5A5A5A5A;
        model_clear();
        clear_stim();
        do_reset();

        // single vector
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'h44332211;
        for (int i = 0; i < N; i++) rdy[i] = 1'b1;
        run(8);
        check("t1_valid_c3", 32'(ov[3]), 32'd0);
        check("t1_valid_c4", 32'(ov[4]), 32'd1);
        check("t1_data_c4", od[4], 32'h44332211);
        check("t1_valid_c5", 32'(ov[5]), 32'd0);

        // back-to-back vectors
        do_reset();
        clear_stim();
        for (int i = 0; i < 4; i++) begin iv[i] = 1'b1; vec[i] = v2[i]; end
        for (int i = 0; i < N; i++) rdy[i] = 1'b1;
        run(12);
        for (int i = 0; i < 4; i++) check("t2_data", od[4+i], v2[i]);
        check("t2_valid_c8", 32'(ov[8]), 32'd0);
        check("t2_overflow", 32'(oovf[11]), 32'd0);

        // backpressure
        do_reset();
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'hDEADBEEF;
        iv[1] = 1'b1; vec[1] = 32'h12345678;
        run(12);
        check("t3_can_accept_c1", 32'(oca[1]), 32'd1);
        check("t3_can_accept_c2", 32'(oca[2]), 32'd0);
        check("t3_occ_c6", 32'(oocc[6]), 32'd2);
        check("t3_hold_c10", od[10], 32'hDEADBEEF);
        check("t3_overflow", 32'(oovf[11]), 32'd0);

        // forced overflow
        do_reset();
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'hCAFE0001;
        iv[1] = 1'b1; vec[1] = 32'hCAFE0002;
        iv[2] = 1'b1; vec[2] = 32'hCAFE0003;
        run(12);
        check("t4_overflow_c5", 32'(oovf[5]), 32'd0);
        check("t4_overflow_c7", 32'(oovf[7]), 32'd1);
        check("t4_overflow_c11", 32'(oovf[11]), 32'd1);
        check("t4_occ_c11", 32'(oocc[11]), 32'd2);
        check("t4_head_c11", od[11], 32'hCAFE0001);

        // full FIFO with simultaneous pop and push
        do_reset();
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'h0A0B0C0D;
        iv[1] = 1'b1; vec[1] = 32'h10203040;
        iv[2] = 1'b1; vec[2] = 32'h77665544;
        rdy[5] = 1'b1;
        run(12);
        check("t5_head_c5", od[5], 32'h0A0B0C0D);
        check("t5_head_c6", od[6], 32'h10203040);
        check("t5_occ_c6", 32'(oocc[6]), 32'd2);
        check("t5_occ_c11", 32'(oocc[11]), 32'd2);
        check("t5_overflow", 32'(oovf[11]), 32'd0);

        // reset with a vector in flight
        do_reset();
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'h99887766;
        rs[2] = 1'b1;
        for (int i = 0; i < N; i++) rdy[i] = 1'b1;
        run(10);
        check("t6_valid_c4", 32'(ov[4]), 32'd0);
        check("t6_occ_c9", 32'(oocc[9]), 32'd0);
        check("t6_can_accept_c9", 32'(oca[9]), 32'd1);

`ifdef COLLECTOR_ACCUM_EN
        // tiled accumulation
        do_reset();
        clear_stim();
        iv[0] = 1'b1; vec[0] = 32'h05050505; il[0] = 1'b0;
        iv[1] = 1'b1; vec[1] = 32'hFEFEFEFE; il[1] = 1'b1;
        iv[2] = 1'b1; vec[2] = 32'h04030201; il[2] = 1'b1;
        for (int i = 0; i < N; i++) rdy[i] = 1'b1;
        run(10);
        check("t7_valid_c4", 32'(ov[4]), 32'd0);
        check("t7_valid_c5", 32'(ov[5]), 32'd1);
        check("t7_data_c5", od[5], 32'h03030303);
        check("t7_data_c6", od[6], 32'h04030201);
        check("t7_valid_c7", 32'(ov[7]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
